// File: rtl/issue_scoreboard.sv
// issue_scoreboard: in-order issue scoreboard with pending-load tracking and drain FSM; define ISSUE_SCOREBOARD_DUAL_EN to allow slot-1 issue
module issue_scoreboard (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid0,
  input  logic        in_valid1,
  input  logic [4:0]  rs1_0,
  input  logic [4:0]  rs2_0,
  input  logic [4:0]  rd_0,
  input  logic [4:0]  rs1_1,
  input  logic [4:0]  rs2_1,
  input  logic [4:0]  rd_1,
  input  logic        wr_0,
  input  logic        wr_1,
  input  logic        ld_0,
  input  logic        ld_1,
  input  logic        ld_done,
  input  logic [4:0]  ld_done_rd,
  input  logic        drain_req,
  output logic        issue0,
  output logic        issue1,
  output logic        stall,
  output logic [4:0]  rf_reg1,
  output logic [4:0]  rf_reg2,
  output logic [4:0]  rf_reg3,
  output logic [4:0]  rf_reg4,
  output logic        drain_done,
  output logic [31:0] busy_vec,
  output logic [1:0]  ld_outstanding
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [31:0] clr_vec, src_busy, set0, set1, busy_nxt;
  logic [1:0] n_ld, cnt_nxt;
  logic [2:0] cnt_sum, cnt_net;
  logic idle;
  assign rf_reg1 = rs1_0;
  assign rf_reg2 = rs2_0;
  assign rf_reg3 = rs1_1;
  assign rf_reg4 = rs2_1;
  // a writeback landing this cycle satisfies readers immediately
  assign clr_vec = (ld_done && ld_done_rd != 5'd0) ? 32'd1 << ld_done_rd : 32'd0;
  assign src_busy = busy_vec & ~clr_vec;
  assign issue0 = state == RUN && in_valid0 && !src_busy[rs1_0] && !src_busy[rs2_0] &&
                  (!ld_0 || ld_outstanding != 2'd2) && !(wr_0 && busy_vec[rd_0]);
  assign stall = in_valid0 && !issue0;
  assign set0 = (issue0 && ld_0 && rd_0 != 5'd0) ? 32'd1 << rd_0 : 32'd0;
`ifdef ISSUE_SCOREBOARD_DUAL_EN
  assign issue1 = issue0 && in_valid1 && !src_busy[rs1_1] && !src_busy[rs2_1] &&
                  !(wr_0 && rd_0 != 5'd0 && (rd_0 == rs1_1 || rd_0 == rs2_1)) &&
                  !(ld_0 && ld_1) && !(wr_0 && wr_1 && rd_0 == rd_1 && ld_0) &&
                  !(wr_1 && busy_vec[rd_1]);
  assign set1 = (issue1 && ld_1 && rd_1 != 5'd0) ? 32'd1 << rd_1 : 32'd0;
`else
  logic unused_slot1;
  assign issue1 = 1'b0;
  assign set1 = 32'd0;
  assign unused_slot1 = ^{in_valid1, rd_1, wr_1};
`endif
  assign n_ld = {1'b0, issue0 && ld_0} + {1'b0, issue1 && ld_1};
  assign cnt_sum = {1'b0, ld_outstanding} + {1'b0, n_ld};
  assign cnt_net = cnt_sum - {2'b0, ld_done && cnt_sum != 3'd0};
  assign cnt_nxt = cnt_net > 3'd2 ? 2'd2 : cnt_net[1:0];
  // new load set wins over a same-cycle clear of the same register
  assign busy_nxt = (src_busy | set0 | set1) & ~32'd1;
  assign idle = ld_outstanding == 2'd0 && busy_vec == 32'd0;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= RUN;
      busy_vec <= 32'd0;
      ld_outstanding <= 2'd0;
      drain_done <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      ld_outstanding <= cnt_nxt;
      drain_done <= state == DRAIN && idle;
      state <= (state == RUN) ? (drain_req ? DRAIN : RUN) :
               (state == DRAIN) ? (idle ? DONE : DRAIN) :
               (drain_req ? DONE : RUN);
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenarios plus randomized traffic against a pending-load reference model
module tb_issue_scoreboard;
`ifdef ISSUE_SCOREBOARD_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  logic clk = 1'b0, n_rst = 1'b1;
  logic in_valid0, in_valid1, wr_0, wr_1, ld_0, ld_1, ld_done, drain_req;
  logic [4:0] rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1, ld_done_rd;
  logic issue0, issue1, stall, drain_done;
  logic [4:0] rf_reg1, rf_reg2, rf_reg3, rf_reg4;
  logic [31:0] busy_vec;
  logic [1:0] ld_outstanding;
  int n_pass = 0, n_total = 0;
  bit pend[32];
  int mcnt, mst;
  bit mdone, m_e0, m_e1, m_stall;
  logic o_i0, o_i1, o_stall;
  logic [19:0] o_rf, m_rf;

  issue_scoreboard dut (
    .clk(clk), .n_rst(n_rst), .in_valid0(in_valid0), .in_valid1(in_valid1),
    .rs1_0(rs1_0), .rs2_0(rs2_0), .rd_0(rd_0), .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1),
    .wr_0(wr_0), .wr_1(wr_1), .ld_0(ld_0), .ld_1(ld_1), .ld_done(ld_done),
    .ld_done_rd(ld_done_rd), .drain_req(drain_req), .issue0(issue0), .issue1(issue1),
    .stall(stall), .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_reg3(rf_reg3), .rf_reg4(rf_reg4),
    .drain_done(drain_done), .busy_vec(busy_vec), .ld_outstanding(ld_outstanding)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mvec();
    logic [31:0] v = 32'd0;
    for (int i = 1; i < 32; i++) v[i] = pend[i];
    return v;
  endfunction

  function automatic bit src_wait(input logic [4:0] r);
    return r != 0 && pend[r] && !(ld_done && ld_done_rd == r);
  endfunction

  // model state: 0 = running, 1 = draining, 2 = drain complete
  task automatic model_comb();
    m_e0 = mst == 0 && in_valid0 && !src_wait(rs1_0) && !src_wait(rs2_0) &&
           (!ld_0 || mcnt < 2) && !(wr_0 && pend[rd_0]);
    m_e1 = DUAL && m_e0 && in_valid1 && !src_wait(rs1_1) && !src_wait(rs2_1) &&
           !(wr_0 && rd_0 != 0 && (rd_0 == rs1_1 || rd_0 == rs2_1)) && !(ld_0 && ld_1) &&
           !(wr_0 && wr_1 && rd_0 == rd_1 && ld_0) && !(wr_1 && pend[rd_1]);
    m_stall = in_valid0 && !m_e0;
    m_rf = {rs1_0, rs2_0, rs1_1, rs2_1};
  endtask

  task automatic model_seq();
    bit all_free = mcnt == 0 && mvec() == 32'd0;
    mdone = 1'b0;
    if (mst == 0) begin
      if (drain_req) mst = 1;
    end else if (mst == 1) begin
      if (all_free) begin mst = 2; mdone = 1'b1; end
    end else if (!drain_req) mst = 0;
    if (ld_done && ld_done_rd != 0) pend[ld_done_rd] = 1'b0;
    if (m_e0 && ld_0 && rd_0 != 0) pend[rd_0] = 1'b1;
    if (m_e1 && ld_1 && rd_1 != 0) pend[rd_1] = 1'b1;
    mcnt = mcnt + int'(m_e0 && ld_0) + int'(m_e1 && ld_1);
    if (ld_done && mcnt > 0) mcnt--;
    if (mcnt > 2) mcnt = 2;
  endtask

  task automatic tick();
    #2;
    model_comb();
    o_i0 = issue0; o_i1 = issue1; o_stall = stall;
    o_rf = {rf_reg1, rf_reg2, rf_reg3, rf_reg4};
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic clear_in();
    {in_valid0, in_valid1, wr_0, wr_1, ld_0, ld_1, ld_done, drain_req} = '0;
    {rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1, ld_done_rd} = '0;
  endtask

  task automatic s0(input logic v, input logic [4:0] a, b, d, input logic w, l);
    in_valid0 = v; rs1_0 = a; rs2_0 = b; rd_0 = d; wr_0 = w; ld_0 = l;
  endtask

  task automatic s1(input logic v, input logic [4:0] a, b, d, input logic w, l);
    in_valid1 = v; rs1_1 = a; rs2_1 = b; rd_1 = d; wr_1 = w; ld_1 = l;
  endtask

  task automatic do_reset();
    clear_in();
    n_rst = 1'b0;
    foreach (pend[i]) pend[i] = 1'b0;
    mcnt = 0; mst = 0; mdone = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 n_rst = 1'b0;
    #1;
    n_total++; if (busy_vec !== 32'd0) $display("FAIL reset_busy got %h exp 0", busy_vec); else n_pass++;
    n_total++; if (ld_outstanding !== 2'd0) $display("FAIL reset_cnt got %0d exp 0", ld_outstanding); else n_pass++;
    n_total++; if (drain_done !== 1'b0) $display("FAIL reset_done got %b exp 0", drain_done); else n_pass++;
    do_reset();
    s0(1, 5'd3, 5'd4, 5'd6, 1, 0); s1(1, 5'd12, 5'd13, 5'd14, 1, 0);
    tick();
    n_total++; if (o_i0 !== 1'b1) $display("FAIL reset_run_issue0 got %b exp 1", o_i0); else n_pass++;
    n_total++; if (o_rf !== {5'd3, 5'd4, 5'd12, 5'd13}) $display("FAIL rf_pass got %h exp %h", o_rf, {5'd3, 5'd4, 5'd12, 5'd13}); else n_pass++;
  endtask

  task automatic test_raw();
    do_reset();
    s0(1, 5'd1, 5'd2, 5'd5, 1, 0); s1(1, 5'd5, 5'd3, 5'd6, 1, 0);
    tick();
    n_total++; if (o_i0 !== 1'b1) $display("FAIL raw_issue0 got %b exp 1", o_i0); else n_pass++;
    n_total++; if (o_i1 !== 1'b0) $display("FAIL raw_issue1 got %b exp 0", o_i1); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    s0(1, 5'd1, 5'd2, 5'd7, 1, 1);
    tick();
    n_total++; if (o_i0 !== 1'b1) $display("FAIL lw7_issue got %b exp 1", o_i0); else n_pass++;
    n_total++; if (busy_vec !== 32'h80) $display("FAIL lw7_busy got %h exp 00000080", busy_vec); else n_pass++;
    s0(1, 5'd1, 5'd7, 5'd8, 1, 0);
    repeat (2) begin
      tick();
      n_total++; if (o_stall !== 1'b1) $display("FAIL use7_stall got %b exp 1", o_stall); else n_pass++;
    end
    ld_done = 1; ld_done_rd = 5'd7;
    tick();
    n_total++; if (o_i0 !== 1'b1) $display("FAIL use7_bypass got %b exp 1", o_i0); else n_pass++;
    n_total++; if (busy_vec !== 32'd0) $display("FAIL use7_clear got %h exp 0", busy_vec); else n_pass++;
  endtask

  task automatic test_waw_alu();
    do_reset();
    s0(1, 5'd1, 5'd2, 5'd9, 1, 0); s1(1, 5'd3, 5'd4, 5'd9, 1, 0);
    tick();
    n_total++; if (o_i0 !== 1'b1) $display("FAIL waw_issue0 got %b exp 1", o_i0); else n_pass++;
    n_total++; if (o_i1 !== DUAL) $display("FAIL waw_issue1 got %b exp %b", o_i1, DUAL); else n_pass++;
    s0(1, 5'd1, 5'd2, 5'd9, 1, 1);
    tick();
    n_total++; if (o_i1 !== 1'b0) $display("FAIL waw_load_issue1 got %b exp 0", o_i1); else n_pass++;
  endtask

  task automatic test_ld_limit();
    do_reset();
    s0(1, 5'd1, 5'd2, 5'd10, 1, 1); tick();
    s0(1, 5'd1, 5'd2, 5'd11, 1, 1); tick();
    n_total++; if (ld_outstanding !== 2'd2) $display("FAIL lim_cnt got %0d exp 2", ld_outstanding); else n_pass++;
    s0(1, 5'd1, 5'd2, 5'd12, 1, 1); tick();
    n_total++; if (o_i0 !== 1'b0) $display("FAIL lim_full got %b exp 0", o_i0); else n_pass++;
    ld_done = 1; ld_done_rd = 5'd10; tick();
    n_total++; if (o_i0 !== 1'b0) $display("FAIL lim_same_cycle got %b exp 0", o_i0); else n_pass++;
    ld_done = 0; tick();
    n_total++; if (o_i0 !== 1'b1) $display("FAIL lim_next got %b exp 1", o_i0); else n_pass++;
    n_total++; if (busy_vec !== 32'h1800) $display("FAIL lim_busy got %h exp 00001800", busy_vec); else n_pass++;
    s0(1, 5'd1, 5'd2, 5'd11, 1, 0); tick();
    n_total++; if (o_i0 !== 1'b0) $display("FAIL waw_busy_rd got %b exp 0", o_i0); else n_pass++;
  endtask

  task automatic test_drain();
    do_reset();
    s0(1, 5'd1, 5'd2, 5'd3, 1, 1); tick();
    s0(0, 5'd0, 5'd0, 5'd0, 0, 0); drain_req = 1; tick();
    s0(1, 5'd1, 5'd2, 5'd4, 1, 0); tick();
    n_total++; if (o_i0 !== 1'b0) $display("FAIL drain_noissue got %b exp 0", o_i0); else n_pass++;
    ld_done = 1; ld_done_rd = 5'd3; tick();
    ld_done = 0;
    n_total++; if (drain_done !== 1'b0) $display("FAIL drain_early got %b exp 0", drain_done); else n_pass++;
    tick();
    n_total++; if (drain_done !== 1'b1) $display("FAIL drain_pulse got %b exp 1", drain_done); else n_pass++;
    n_total++; if (busy_vec !== 32'd0) $display("FAIL drain_busy got %h exp 0", busy_vec); else n_pass++;
    drain_req = 0; tick();
    n_total++; if (o_i0 !== 1'b0) $display("FAIL done_noissue got %b exp 0", o_i0); else n_pass++;
    n_total++; if (drain_done !== 1'b0) $display("FAIL drain_onecycle got %b exp 0", drain_done); else n_pass++;
    tick();
    n_total++; if (o_i0 !== 1'b1) $display("FAIL drain_resume got %b exp 1", o_i0); else n_pass++;
  endtask

  task automatic test_rd0_reset();
    do_reset();
    s0(1, 5'd1, 5'd2, 5'd0, 1, 1); tick();
    n_total++; if (busy_vec !== 32'd0) $display("FAIL rd0_busy got %h exp 0", busy_vec); else n_pass++;
    n_total++; if (ld_outstanding !== 2'd1) $display("FAIL rd0_cnt got %0d exp 1", ld_outstanding); else n_pass++;
    s0(0, 5'd0, 5'd0, 5'd0, 0, 0); drain_req = 1; tick(); tick();
    n_rst = 1'b0;
    #1;
    n_total++; if (ld_outstanding !== 2'd0) $display("FAIL midreset_cnt got %0d exp 0", ld_outstanding); else n_pass++;
    do_reset();
    s0(1, 5'd1, 5'd2, 5'd4, 1, 0); ld_done = 1; ld_done_rd = 5'd5; tick();
    n_total++; if (o_i0 !== 1'b1) $display("FAIL midreset_run got %b exp 1", o_i0); else n_pass++;
    n_total++; if (ld_outstanding !== 2'd0) $display("FAIL stray_done_cnt got %0d exp 0", ld_outstanding); else n_pass++;
    n_total++; if (busy_vec !== 32'd0) $display("FAIL stray_done_busy got %h exp 0", busy_vec); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      s0($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      s1($urandom_range(0, 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      ld_done = $urandom_range(0, 2) == 0;
      ld_done_rd = 5'($urandom_range(0, 7));
      drain_req = $urandom_range(0, 15) == 0;
      tick();
      n_total++; if (o_i0 !== m_e0) $display("FAIL rnd_issue0 cyc %0d got %b exp %b", n, o_i0, m_e0); else n_pass++;
      n_total++; if (o_i1 !== m_e1) $display("FAIL rnd_issue1 cyc %0d got %b exp %b", n, o_i1, m_e1); else n_pass++;
      n_total++; if (o_stall !== m_stall) $display("FAIL rnd_stall cyc %0d got %b exp %b", n, o_stall, m_stall); else n_pass++;
      n_total++; if (o_rf !== m_rf) $display("FAIL rnd_rf cyc %0d got %h exp %h", n, o_rf, m_rf); else n_pass++;
      n_total++; if (busy_vec !== mvec()) $display("FAIL rnd_busy cyc %0d got %h exp %h", n, busy_vec, mvec()); else n_pass++;
      n_total++; if (ld_outstanding !== 2'(mcnt)) $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", n, ld_outstanding, mcnt); else n_pass++;
      n_total++; if (drain_done !== mdone) $display("FAIL rnd_done cyc %0d got %b exp %b", n, drain_done, mdone); else n_pass++;
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_raw();
    test_load_use();
    test_waw_alu();
    test_ld_limit();
    test_drain();
    test_rd0_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
